sd_bit_serializer: RTL and testbench

//  Parallel-to-serial front end for the Moore sequence-detector FSM. Accepts WIDTH-bit words over a

---
 rtl/sd_bit_serializer.sv | 157 +++++++++++++++
 tb/tb_sd_bit_serializer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_bit_serializer.sv
// Parallel-to-serial front end feeding the sequence detector's serial input.
// Optional one-word prefetch register for gapless streaming: define SD_SER_PREFETCH_EN.
module sd_bit_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned BIT_DIV   = 1,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             sequence_out,
  output logic             bit_valid,
  output logic             bit_strobe,
  output logic             word_done,
  output logic             busy
);

  localparam int unsigned BCW = $clog2(WIDTH);
  localparam int unsigned DCW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);
  localparam logic [DCW-1:0] DIV_LAST = DCW'(BIT_DIV - 1);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [BCW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DCW-1:0]     div_cnt_q, div_cnt_d;
  logic               in_ready_q, in_ready_d;
  logic               seq_q, seq_d;
  logic               bit_valid_q, bit_valid_d;
  logic               strobe_q, strobe_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
`ifdef SD_SER_PREFETCH_EN
  logic [WIDTH-1:0]   hold_q, hold_d;
  logic               hold_valid_q, hold_valid_d;
`endif

  logic hs_c;
  logic final_c;
  logic [WIDTH-1:0] shifted_c;

  // Next-state, counters and registered-output decode
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
`ifdef SD_SER_PREFETCH_EN
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
`endif
    hs_c      = in_valid & in_ready_q;
    final_c   = (state_q == SHIFT) && (bit_cnt_q == BIT_LAST) && (div_cnt_q == DIV_LAST);
    shifted_c = (MSB_FIRST != 0) ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};

    case (state_q)
      IDLE: begin
        if (hs_c) begin
          shreg_d   = in_data;
          bit_cnt_d = '0;
          div_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (final_c) begin
          bit_cnt_d = '0;
          div_cnt_d = '0;
`ifdef SD_SER_PREFETCH_EN
          if (hold_valid_q) begin
            shreg_d      = hold_q;
            hold_valid_d = 1'b0;
          end else if (hs_c) begin
            shreg_d = in_data;
          end else begin
            state_d = IDLE;
          end
`else
          state_d = IDLE;
`endif
        end else if (div_cnt_q == DIV_LAST) begin
          shreg_d   = shifted_c;
          bit_cnt_d = bit_cnt_q + BCW'(1);
          div_cnt_d = '0;
        end else begin
          div_cnt_d = div_cnt_q + DCW'(1);
        end
`ifdef SD_SER_PREFETCH_EN
        // Words arriving mid-word park in the hold register
        if (hs_c && !final_c) begin
          hold_d       = in_data;
          hold_valid_d = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase

`ifdef SD_SER_PREFETCH_EN
    in_ready_d = !hold_valid_d;
`else
    in_ready_d = (state_d == IDLE);
`endif
    busy_d      = (state_d == SHIFT);
    bit_valid_d = (state_d == SHIFT);
    seq_d       = (state_d == SHIFT) &&
                  ((MSB_FIRST != 0) ? shreg_d[WIDTH-1] : shreg_d[0]);
    strobe_d    = (state_d == SHIFT) && (div_cnt_d == '0);
    done_d      = (state_d == SHIFT) && (bit_cnt_d == BIT_LAST) && (div_cnt_d == DIV_LAST);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      div_cnt_q   <= '0;
      in_ready_q  <= 1'b1;
      seq_q       <= 1'b0;
      bit_valid_q <= 1'b0;
      strobe_q    <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SD_SER_PREFETCH_EN
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      div_cnt_q   <= div_cnt_d;
      in_ready_q  <= in_ready_d;
      seq_q       <= seq_d;
      bit_valid_q <= bit_valid_d;
      strobe_q    <= strobe_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
`ifdef SD_SER_PREFETCH_EN
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
`endif
    end
  end

  assign in_ready     = in_ready_q;
  assign sequence_out = seq_q;
  assign bit_valid    = bit_valid_q;
  assign bit_strobe   = strobe_q;
  assign word_done    = done_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_sd_bit_serializer.sv
// Scoreboard bench for sd_bit_serializer: three instances cover bit divider and bit order.
module tb_sd_bit_serializer;

`ifdef SD_SER_PREFETCH_EN
  localparam int EXP_GAPS   = 0;
  localparam int EXP_LAST   = 16;
  localparam logic EXP_RDY1 = 1'b1;
`else
  localparam int EXP_GAPS   = 1;
  localparam int EXP_LAST   = 17;
  localparam logic EXP_RDY1 = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic [7:0] in_data_a, in_data_b, in_data_l;
  logic in_valid_a, in_valid_b, in_valid_l;
  logic in_ready_a, seq_a, bit_valid_a, bit_strobe_a, word_done_a, busy_a;
  logic in_ready_b, seq_b, bit_valid_b, bit_strobe_b, word_done_b, busy_b;
  logic in_ready_l, seq_l, bit_valid_l, bit_strobe_l, word_done_l, busy_l;

  sd_bit_serializer #(.WIDTH(8), .BIT_DIV(1), .MSB_FIRST(1)) u_dut_a (
    .clock(clock), .reset(reset), .in_data(in_data_a), .in_valid(in_valid_a),
    .in_ready(in_ready_a), .sequence_out(seq_a), .bit_valid(bit_valid_a),
    .bit_strobe(bit_strobe_a), .word_done(word_done_a), .busy(busy_a));

  sd_bit_serializer #(.WIDTH(8), .BIT_DIV(3), .MSB_FIRST(1)) u_dut_b (
    .clock(clock), .reset(reset), .in_data(in_data_b), .in_valid(in_valid_b),
    .in_ready(in_ready_b), .sequence_out(seq_b), .bit_valid(bit_valid_b),
    .bit_strobe(bit_strobe_b), .word_done(word_done_b), .busy(busy_b));

  sd_bit_serializer #(.WIDTH(8), .BIT_DIV(1), .MSB_FIRST(0)) u_dut_l (
    .clock(clock), .reset(reset), .in_data(in_data_l), .in_valid(in_valid_l),
    .in_ready(in_ready_l), .sequence_out(seq_l), .bit_valid(bit_valid_l),
    .bit_strobe(bit_strobe_l), .word_done(word_done_l), .busy(busy_l));

  int checks = 0;
  int errors = 0;
  logic exp_q[$];

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic push_word(input logic [7:0] w, input bit msb, input int rep);
    for (int i = 0; i < 8; i++)
      for (int r = 0; r < rep; r++)
        exp_q.push_back(msb ? w[7-i] : w[i]);
  endtask

  task automatic test_reset();
    logic [5:0] a, b, l;
    reset = 1'b1;
    in_valid_a = 1'b0; in_valid_b = 1'b0; in_valid_l = 1'b0;
    in_data_a = 8'h00; in_data_b = 8'h00; in_data_l = 8'h00;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    a = {seq_a, bit_valid_a, bit_strobe_a, word_done_a, busy_a, in_ready_a};
    b = {seq_b, bit_valid_b, bit_strobe_b, word_done_b, busy_b, in_ready_b};
    l = {seq_l, bit_valid_l, bit_strobe_l, word_done_l, busy_l, in_ready_l};
    checks++;
    if (a !== 6'b000001) begin errors++; $display("FAIL reset_a got %b expected 000001", a); end
    checks++;
    if (b !== 6'b000001) begin errors++; $display("FAIL reset_b got %b expected 000001", b); end
    checks++;
    if (l !== 6'b000001) begin errors++; $display("FAIL reset_l got %b expected 000001", l); end
  endtask

  task automatic test_basic();
    logic e;
    exp_q.delete();
    in_data_a = 8'hB0; in_valid_a = 1'b1;
    push_word(8'hB0, 1'b1, 1);
    tick();
    in_valid_a = 1'b0; in_data_a = 8'h5A;
    for (int c = 1; c <= 9; c++) begin
      checks++;
      if (bit_strobe_a !== (c <= 8)) begin errors++; $display("FAIL basic_strobe cycle %0d got %b", c, bit_strobe_a); end
      checks++;
      if (word_done_a !== (c == 8)) begin errors++; $display("FAIL basic_done cycle %0d got %b", c, word_done_a); end
      checks++;
      if (in_ready_a !== (c == 9)) begin errors++; $display("FAIL basic_ready cycle %0d got %b", c, in_ready_a); end
      checks++;
      if (bit_valid_a !== (c <= 8)) begin errors++; $display("FAIL basic_valid cycle %0d got %b", c, bit_valid_a); end
      if (bit_valid_a === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL basic_bit cycle %0d unexpected bit", c); end
        else begin
          e = exp_q.pop_front();
          if (seq_a !== e) begin errors++; $display("FAIL basic_bit cycle %0d got %b expected %b", c, seq_a, e); end
        end
      end else begin
        checks++;
        if (seq_a !== 1'b0) begin errors++; $display("FAIL basic_idle_seq cycle %0d got %b expected 0", c, seq_a); end
      end
      tick();
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL basic_left got %0d bits expected 0", exp_q.size()); end
  endtask

  task automatic test_bitdiv();
    logic e;
    exp_q.delete();
    in_data_b = 8'hB0; in_valid_b = 1'b1;
    push_word(8'hB0, 1'b1, 3);
    tick();
    in_valid_b = 1'b0;
    for (int c = 1; c <= 25; c++) begin
      checks++;
      if (bit_strobe_b !== (c <= 24 && ((c - 1) % 3) == 0)) begin
        errors++; $display("FAIL div_strobe cycle %0d got %b", c, bit_strobe_b);
      end
      checks++;
      if (word_done_b !== (c == 24)) begin errors++; $display("FAIL div_done cycle %0d got %b", c, word_done_b); end
      checks++;
      if (busy_b !== (c <= 24)) begin errors++; $display("FAIL div_busy cycle %0d got %b", c, busy_b); end
      if (bit_valid_b === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL div_bit cycle %0d unexpected bit", c); end
        else begin
          e = exp_q.pop_front();
          if (seq_b !== e) begin errors++; $display("FAIL div_bit cycle %0d got %b expected %b", c, seq_b, e); end
        end
      end
      tick();
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL div_left got %0d bits expected 0", exp_q.size()); end
  endtask

  task automatic test_lsb_first();
    logic e;
    exp_q.delete();
    in_data_l = 8'h0D; in_valid_l = 1'b1;
    push_word(8'h0D, 1'b0, 1);
    tick();
    in_valid_l = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      checks++;
      if (bit_valid_l !== (c <= 8)) begin errors++; $display("FAIL lsb_valid cycle %0d got %b", c, bit_valid_l); end
      checks++;
      if (word_done_l !== (c == 8)) begin errors++; $display("FAIL lsb_done cycle %0d got %b", c, word_done_l); end
      if (bit_valid_l === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL lsb_bit cycle %0d unexpected bit", c); end
        else begin
          e = exp_q.pop_front();
          if (seq_l !== e) begin errors++; $display("FAIL lsb_bit cycle %0d got %b expected %b", c, seq_l, e); end
        end
      end
      tick();
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL lsb_left got %0d bits expected 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    logic e;
    int hs_n, first_v, last_v, n_v;
    exp_q.delete();
    hs_n = 1; first_v = 0; last_v = 0; n_v = 0;
    in_data_a = 8'hB0; in_valid_a = 1'b1;
    push_word(8'hB0, 1'b1, 1);
    tick();
    in_data_a = 8'h0B;
    for (int c = 1; c <= 20; c++) begin
      if (hs_n >= 2) in_valid_a = 1'b0;
      if (in_valid_a && in_ready_a) begin
        hs_n++;
        push_word(8'h0B, 1'b1, 1);
      end
      if (c == 1) begin
        checks++;
        if (in_ready_a !== EXP_RDY1) begin errors++; $display("FAIL b2b_ready1 got %b expected %b", in_ready_a, EXP_RDY1); end
      end
      if (c == 2) begin
        checks++;
        if (in_ready_a !== 1'b0) begin errors++; $display("FAIL b2b_ready2 got %b expected 0", in_ready_a); end
      end
      if (bit_valid_a === 1'b1) begin
        n_v++;
        if (first_v == 0) first_v = c;
        last_v = c;
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_bit cycle %0d unexpected bit", c); end
        else begin
          e = exp_q.pop_front();
          if (seq_a !== e) begin errors++; $display("FAIL b2b_bit cycle %0d got %b expected %b", c, seq_a, e); end
        end
      end
      tick();
    end
    in_valid_a = 1'b0;
    checks++;
    if (n_v != 16) begin errors++; $display("FAIL b2b_count got %0d expected 16", n_v); end
    checks++;
    if (last_v != EXP_LAST) begin errors++; $display("FAIL b2b_last got %0d expected %0d", last_v, EXP_LAST); end
    checks++;
    if (last_v - first_v + 1 - n_v != EXP_GAPS) begin
      errors++; $display("FAIL b2b_gaps got %0d expected %0d", last_v - first_v + 1 - n_v, EXP_GAPS);
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_left got %0d bits expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_word();
    logic e;
    exp_q.delete();
    in_data_a = 8'hB0; in_valid_a = 1'b1;
    tick();
    in_valid_a = 1'b0;
    repeat (3) tick();
    checks++;
    if ({bit_valid_a, seq_a} !== 2'b11) begin errors++; $display("FAIL rst_pre got %b expected 11", {bit_valid_a, seq_a}); end
    reset = 1'b1;
    #1;
    checks++;
    if ({seq_a, bit_valid_a, busy_a, in_ready_a} !== 4'b0001) begin
      errors++; $display("FAIL rst_async got %b expected 0001", {seq_a, bit_valid_a, busy_a, in_ready_a});
    end
    tick();
    reset = 1'b0;
    tick();
    in_data_a = 8'hFF; in_valid_a = 1'b1;
    push_word(8'hFF, 1'b1, 1);
    tick();
    in_valid_a = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      checks++;
      if (bit_valid_a !== (c <= 8)) begin errors++; $display("FAIL rst_valid cycle %0d got %b", c, bit_valid_a); end
      if (bit_valid_a === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL rst_bit cycle %0d unexpected bit", c); end
        else begin
          e = exp_q.pop_front();
          if (seq_a !== e) begin errors++; $display("FAIL rst_bit cycle %0d got %b expected %b", c, seq_a, e); end
        end
      end
      tick();
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rst_left got %0d bits expected 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bitdiv();
    test_lsb_first();
    test_back_to_back();
    test_reset_mid_word();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
